// File: rtl/case_enc_if.sv
// Handshake bundle for the case encoder: decoded vector in, recovered code out.
interface case_enc_if #(parameter int SIZE = 3);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      a;
    logic            err;

    modport master (
        output in_valid, b, out_ready,
        input  in_ready, out_valid, a, err
    );

    modport slave (
        input  in_valid, b, out_ready,
        output in_ready, out_valid, a, err
    );
endinterface

// File: rtl/case_enc.sv
// Recovers the 2-bit code from a one-hot-style decoded vector through a 2-entry
// output buffer; illegal vectors are flagged, counted (saturating) and captured.
//
// state | meaning
// EMPTY | buffer holds no entries, out_valid low
// ONE   | one entry buffered, can accept and release in the same cycle
// FULL  | two entries buffered, in_ready low
module case_enc #(
    parameter int SIZE  = 3,
    parameter int ERR_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    case_enc_if.slave        bus,
    output logic [ERR_W-1:0] err_cnt,
    output logic [SIZE-1:0]  err_last
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       buf_a_q [2];
    logic [1:0]       buf_a_d [2];
    logic             buf_err_q [2];
    logic             buf_err_d [2];
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [SIZE-1:0]  err_last_q, err_last_d;

    logic [2:0]       b_ext;
    logic [1:0]       dec_a;
    logic             dec_ill;
    logic             accept;
    logic             release_head;

    // Narrow vectors are zero-extended so the same map covers every SIZE.
    always_comb begin
        b_ext             = '0;
        b_ext[SIZE-1:0]   = bus.b;
        dec_a             = 2'd0;
        dec_ill           = 1'b0;
        case (b_ext)
            3'b000:  dec_a = 2'd0;
            3'b001:  dec_a = 2'd1;
            3'b010:  dec_a = 2'd2;
            3'b100:  dec_a = 2'd3;
            default: dec_ill = 1'b1;
        endcase
    end

    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.a         = buf_a_q[rd_ptr_q];
    assign bus.err       = buf_err_q[rd_ptr_q];
    assign err_cnt       = err_cnt_q;
    assign err_last      = err_last_q;

    assign accept       = bus.in_valid & bus.in_ready;
    assign release_head = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q ^ accept;
        rd_ptr_d   = rd_ptr_q ^ release_head;
        buf_a_d    = buf_a_q;
        buf_err_d  = buf_err_q;
        err_cnt_d  = err_cnt_q;
        err_last_d = err_last_q;

        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !release_head)      state_d = FULL;
                else if (release_head && !accept) state_d = EMPTY;
            end
            FULL:    if (release_head) state_d = ONE;
            default: state_d = EMPTY;
        endcase

        if (accept) begin
            buf_a_d[wr_ptr_q]   = dec_a;
            buf_err_d[wr_ptr_q] = dec_ill;
            if (dec_ill) begin
                err_last_d = bus.b;
                if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            buf_a_q[0]   <= 2'd0;
            buf_a_q[1]   <= 2'd0;
            buf_err_q[0] <= 1'b0;
            buf_err_q[1] <= 1'b0;
            err_cnt_q    <= '0;
            err_last_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_a_q    <= buf_a_d;
            buf_err_q  <= buf_err_d;
            err_cnt_q  <= err_cnt_d;
            err_last_q <= err_last_d;
        end
    end

endmodule

// File: tb/tb_case_enc.sv
// Directed bench for case_enc: a default-width instance and an ERR_W=2 twin share stimulus.
module tb_case_enc;

    logic       clock;
    logic       reset_n;
    logic [3:0] err_cnt4;
    logic [2:0] err_last4;
    logic [1:0] err_cnt2;
    logic [2:0] err_last2;

    int n_checks = 0;
    int n_fail   = 0;

    case_enc_if #(.SIZE(3)) ifa ();
    case_enc_if #(.SIZE(3)) ifb ();

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.b         = ifa.b;
    assign ifb.out_ready = ifa.out_ready;

    case_enc #(.SIZE(3), .ERR_W(4)) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (ifa.slave),
        .err_cnt  (err_cnt4),
        .err_last (err_last4)
    );

    case_enc #(.SIZE(3), .ERR_W(2)) u_dut2 (
        .clock    (clock),
        .reset_n  (reset_n),
        .bus      (ifb.slave),
        .err_cnt  (err_cnt2),
        .err_last (err_last2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [2:0] vec;
    logic [2:0] ill  [5];
    logic [2:0] leg  [6];
    int         code [6];
    int         e2;

    initial begin
        ill  = '{3'b110, 3'b101, 3'b011, 3'b111, 3'b110};
        leg  = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b010};
        code = '{1, 2, 3, 0, 1, 2};

        reset_n       = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.b         = 3'b000;
        ifa.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(ifa.out_valid), 0);
        chk("rst_in_ready",  32'(ifa.in_ready),  1);
        chk("rst_a",         32'(ifa.a),         0);
        chk("rst_err",       32'(ifa.err),       0);
        chk("rst_err_cnt",   32'(err_cnt4),      0);
        chk("rst_err_last",  32'(err_last4),     0);
        reset_n = 1'b1;
        tick();
        chk("idle_out_valid", 32'(ifa.out_valid), 0);

        // Back-to-back legal vectors with the consumer always ready.
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vec   = 3'b000;
            if (i > 0) vec[i-1] = 1'b1;
            ifa.b = vec;
            tick();
            chk("t1_out_valid", 32'(ifa.out_valid), 1);
            chk("t1_a",         32'(ifa.a),         32'(i));
            chk("t1_err",       32'(ifa.err),       0);
        end
        chk("t1_err_cnt", 32'(err_cnt4), 0);
        ifa.in_valid = 1'b0;
        tick();
        chk("t1_drain", 32'(ifa.out_valid), 0);

        // Back-pressure: fill the buffer, third vector waits.
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.b         = 3'b001;
        tick();
        chk("t2_a_first",   32'(ifa.a),        1);
        chk("t2_rdy_one",   32'(ifa.in_ready), 1);
        ifa.b = 3'b010;
        tick();
        chk("t2_rdy_full",  32'(ifa.in_ready), 0);
        chk("t2_hold_a",    32'(ifa.a),        1);
        ifa.b = 3'b100;
        tick();
        chk("t2_rdy_stall", 32'(ifa.in_ready), 0);
        chk("t2_hold_a2",   32'(ifa.a),        1);
        ifa.out_ready = 1'b1;
        tick();
        chk("t2_drain_a2",  32'(ifa.a),        2);
        chk("t2_rdy_back",  32'(ifa.in_ready), 1);
        tick();
        chk("t2_third_a",   32'(ifa.a),        3);
        chk("t2_third_v",   32'(ifa.out_valid), 1);
        ifa.in_valid = 1'b0;
        tick();
        chk("t2_empty", 32'(ifa.out_valid), 0);

        // Illegal vectors.
        ifa.in_valid = 1'b1;
        ifa.b        = 3'b011;
        tick();
        chk("t3_err1",     32'(ifa.err),   1);
        chk("t3_a1",       32'(ifa.a),     0);
        chk("t3_cnt1",     32'(err_cnt4),  1);
        chk("t3_last1",    32'(err_last4), 32'(3'b011));
        ifa.b = 3'b111;
        tick();
        chk("t3_err2",     32'(ifa.err),   1);
        chk("t3_a2",       32'(ifa.a),     0);
        chk("t3_cnt2",     32'(err_cnt4),  2);
        chk("t3_last2",    32'(err_last4), 32'(3'b111));
        ifa.in_valid = 1'b0;
        ifa.b        = 3'b101;
        tick();
        chk("t3_ign_cnt",  32'(err_cnt4),  2);
        chk("t3_ign_last", 32'(err_last4), 32'(3'b111));
        chk("t3_ign_v",    32'(ifa.out_valid), 0);

        // Saturation: narrow counter sticks at 3, wide counter keeps going.
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ifa.b = ill[k];
            tick();
            e2 = (3 + k > 3) ? 3 : 3 + k;
            chk("t4_cnt2", 32'(err_cnt2), 32'(e2));
            chk("t4_cnt4", 32'(err_cnt4), 32'(3 + k));
        end
        chk("t4_last2", 32'(err_last2), 32'(3'b110));
        ifa.in_valid = 1'b0;
        tick();

        // Steady state with one entry: simultaneous accept and release.
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.b         = 3'b000;
        tick();
        chk("t5_prime", 32'(ifa.out_valid), 1);
        ifa.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ifa.b = leg[k];
            tick();
            chk("t5_a",   32'(ifa.a),         32'(code[k]));
            chk("t5_rdy", 32'(ifa.in_ready),  1);
            chk("t5_vld", 32'(ifa.out_valid), 1);
            chk("t5_err", 32'(ifa.err),       0);
        end
        chk("t5_cnt", 32'(err_cnt4), 7);
        ifa.in_valid = 1'b0;
        tick();
        chk("t5_empty", 32'(ifa.out_valid), 0);

        // Async reset while full.
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        chk("t6_cnt_clr", 32'(err_cnt4), 0);
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.b         = 3'b011;
        tick();
        ifa.b = 3'b001;
        tick();
        chk("t6_full",    32'(ifa.in_ready), 0);
        chk("t6_cnt_pre", 32'(err_cnt4),     1);
        ifa.in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_vld",  32'(ifa.out_valid), 0);
        chk("t6_rst_rdy",  32'(ifa.in_ready),  1);
        chk("t6_rst_cnt",  32'(err_cnt4),      0);
        chk("t6_rst_cnt2", 32'(err_cnt2),      0);
        chk("t6_rst_err",  32'(ifa.err),       0);
        chk("t6_rst_last", 32'(err_last4),     0);
        #1;
        reset_n       = 1'b1;
        ifa.out_ready = 1'b1;
        ifa.in_valid  = 1'b1;
        ifa.b         = 3'b010;
        tick();
        chk("t6_post_a",   32'(ifa.a),         2);
        chk("t6_post_vld", 32'(ifa.out_valid), 1);
        chk("t6_post_err", 32'(ifa.err),       0);
        ifa.in_valid = 1'b0;
        tick();
        chk("t6_post_empty", 32'(ifa.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
